// File: rtl/data_ram_if.sv
// RAM bus between the memory controller (master) and the data RAM responder (slave).
// The controller issues one request at a time; the responder acks each one once.
interface data_ram_if;
  logic        ram_req;
  logic        ram_rw_flag;
  logic [15:0] address_add_bus;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;
  logic        ram_ack;
  logic        ram_busy;
  logic        ram_err;

  modport master (
    output ram_req,
    output ram_rw_flag,
    output address_add_bus,
    output ram_data_in,
    input  ram_data_out,
    input  ram_ack,
    input  ram_busy,
    input  ram_err
  );

  modport slave (
    input  ram_req,
    input  ram_rw_flag,
    input  address_add_bus,
    input  ram_data_in,
    output ram_data_out,
    output ram_ack,
    output ram_busy,
    output ram_err
  );
endinterface

// File: rtl/data_ram_responder.sv
// Single-outstanding data RAM responder: captures a request, waits WAIT_STATES cycles,
// performs the read or write, then pulses ram_ack for one cycle.
module data_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic      clk,
  input  logic      rst,
  data_ram_if.slave ram_bus
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  // Address bits above the implemented range; all-zero when ADDR_WIDTH is 16.
  localparam logic [15:0] HiMask   = 16'(~((17'd1 << ADDR_WIDTH) - 17'd1));
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [Depth];
  logic            addr_oor;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic            mem_we;

  assign addr_oor = |(addr_q & HiMask);
  assign mem_idx  = addr_q[ADDR_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      StIdle: begin
        if (ram_bus.ram_req) begin
          addr_d  = ram_bus.address_add_bus;
          rw_d    = ram_bus.ram_rw_flag;
          wdata_d = ram_bus.ram_data_in;
          cnt_d   = WaitLoad;
          busy_d  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StAck;
          ack_d   = 1'b1;
          err_d   = addr_oor;
          // Out-of-range accesses never touch the array, so no aliasing.
          if (rw_q) begin
            rdata_d = addr_oor ? 32'd0 : mem_q[mem_idx];
          end else begin
            mem_we = ~addr_oor;
          end
        end
      end
      StAck: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      rw_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end

  assign ram_bus.ram_data_out = rdata_q;
  assign ram_bus.ram_ack      = ack_q;
  assign ram_bus.ram_busy     = busy_q;
  assign ram_bus.ram_err      = err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: one instance with 2 wait states and one with none,
// checked every cycle against an edge-counting transaction model plus directed literals.
module tb_data_ram_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  data_ram_if bus_a ();
  data_ram_if bus_b ();

  logic        req_v  [2];
  logic        rw_v   [2];
  logic [15:0] addr_v [2];
  logic [31:0] wd_v   [2];
  logic [31:0] dout_v [2];
  logic        ack_v  [2];
  logic        busy_v [2];
  logic        err_v  [2];

  assign bus_a.ram_req         = req_v[0];
  assign bus_a.ram_rw_flag     = rw_v[0];
  assign bus_a.address_add_bus = addr_v[0];
  assign bus_a.ram_data_in     = wd_v[0];
  assign dout_v[0]             = bus_a.ram_data_out;
  assign ack_v[0]              = bus_a.ram_ack;
  assign busy_v[0]             = bus_a.ram_busy;
  assign err_v[0]              = bus_a.ram_err;

  assign bus_b.ram_req         = req_v[1];
  assign bus_b.ram_rw_flag     = rw_v[1];
  assign bus_b.address_add_bus = addr_v[1];
  assign bus_b.ram_data_in     = wd_v[1];
  assign dout_v[1]             = bus_b.ram_data_out;
  assign ack_v[1]              = bus_b.ram_ack;
  assign busy_v[1]             = bus_b.ram_busy;
  assign err_v[1]              = bus_b.ram_err;

  data_ram_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_ws2 (
    .clk     (clk),
    .rst     (rst),
    .ram_bus (bus_a.slave)
  );

  data_ram_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_ws0 (
    .clk     (clk),
    .rst     (rst),
    .ram_bus (bus_b.slave)
  );

  function automatic int ws(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts edges since reset; a request captured at edge k completes at
  // edge k+ws+1 and the next capture is allowed from edge k+ws+3.
  int          edge_k  [2];
  int          ack_k   [2];
  int          free_k  [2];
  bit          pend    [2];
  bit          m_rw    [2];
  logic [15:0] m_addr  [2];
  logic [31:0] m_data  [2];
  logic [31:0] mmem    [2][256];
  bit          exp_ack [2];
  bit          exp_busy[2];
  bit          exp_err [2];
  logic [31:0] exp_dout[2];

  initial begin : model
    bit oor;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mmem[d][i] = 32'd0;
      edge_k[d] = 0; ack_k[d] = 0; free_k[d] = 0; pend[d] = 1'b0;
      exp_ack[d] = 1'b0; exp_busy[d] = 1'b0; exp_err[d] = 1'b0; exp_dout[d] = 32'd0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          edge_k[d] = 0; free_k[d] = 0; pend[d] = 1'b0;
          exp_ack[d] = 1'b0; exp_busy[d] = 1'b0; exp_err[d] = 1'b0; exp_dout[d] = 32'd0;
        end else begin
          edge_k[d]++;
          exp_ack[d] = 1'b0;
          exp_err[d] = 1'b0;
          if (pend[d] && edge_k[d] == ack_k[d]) begin
            oor = (m_addr[d] >= 16'd256);
            if (m_rw[d]) exp_dout[d] = oor ? 32'd0 : mmem[d][m_addr[d][7:0]];
            else if (!oor) mmem[d][m_addr[d][7:0]] = m_data[d];
            exp_ack[d] = 1'b1;
            exp_err[d] = oor;
            pend[d]    = 1'b0;
            free_k[d]  = edge_k[d] + 2;
          end else if (!pend[d] && edge_k[d] >= free_k[d] && req_v[d] === 1'b1) begin
            pend[d]   = 1'b1;
            m_rw[d]   = rw_v[d];
            m_addr[d] = addr_v[d];
            m_data[d] = wd_v[d];
            ack_k[d]  = edge_k[d] + ws(d) + 1;
          end
          exp_busy[d] = pend[d] || exp_ack[d];
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d_ack", d),  32'(ack_v[d]),  32'(exp_ack[d]));
        chk($sformatf("dut%0d_busy", d), 32'(busy_v[d]), 32'(exp_busy[d]));
        chk($sformatf("dut%0d_err", d),  32'(err_v[d]),  32'(exp_err[d]));
        chk($sformatf("dut%0d_dout", d), dout_v[d],      exp_dout[d]);
      end
    end
  end

  task automatic issue(int d, bit rw, logic [15:0] a, logic [31:0] wd);
    @(negedge clk);
    req_v[d] = 1'b1; rw_v[d] = rw; addr_v[d] = a; wd_v[d] = wd;
    @(negedge clk);
    // Scramble inputs after capture; only latched values may matter.
    req_v[d] = 1'b0; rw_v[d] = ~rw; addr_v[d] = 16'hFFFF; wd_v[d] = ~wd;
  endtask

  task automatic wait_ack(int d, output int n);
    n = 0;
    while (ack_v[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ack_v[d] !== 1'b1) chk($sformatf("dut%0d_ack_timeout", d), 32'd0, 32'd1);
  endtask

  task automatic txn(int d, bit rw, logic [15:0] a, logic [31:0] wd,
                     output int n, output logic [31:0] data, output logic err);
    issue(d, rw, a, wd);
    wait_ack(d, n);
    data = dout_v[d];
    err  = err_v[d];
  endtask

  initial begin : stim
    int          n, g, acks;
    logic [31:0] data;
    logic        err;

    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; rw_v[d] = 1'b0; addr_v[d] = 16'd0; wd_v[d] = 32'd0;
    end

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_async_ack",  32'(ack_v[d]),  32'd0);
      chk("rst_async_busy", 32'(busy_v[d]), 32'd0);
      chk("rst_async_err",  32'(err_v[d]),  32'd0);
      chk("rst_async_dout", dout_v[d],      32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack_v[0] === 1'b1 || ack_v[1] === 1'b1) acks++;
    end
    chk("idle_no_ack", 32'(acks), 32'd0);

    // Two wait states: write then read back.
    txn(0, 1'b0, 16'h0012, 32'hDEADBEEF, n, data, err);
    chk("ws2_write_latency", 32'(n), 32'd3);
    chk("ws2_write_dout_held", data, 32'd0);
    chk("ws2_write_err", 32'(err), 32'd0);
    txn(0, 1'b1, 16'h0012, 32'h0, n, data, err);
    chk("ws2_read_latency", 32'(n), 32'd3);
    chk("ws2_read_data", data, 32'hDEADBEEF);
    chk("ws2_read_err", 32'(err), 32'd0);

    txn(0, 1'b0, 16'h0034, 32'h00000034, n, data, err);
    txn(0, 1'b0, 16'h0000, 32'h11110000, n, data, err);
    txn(0, 1'b0, 16'h0005, 32'hA5A5A5A5, n, data, err);

    // Busy ignore: req held, address changes right after capture.
    @(negedge clk);
    req_v[0] = 1'b1; rw_v[0] = 1'b1; addr_v[0] = 16'h0012;
    @(negedge clk);
    addr_v[0] = 16'h0034;
    wait_ack(0, n);
    chk("busy_ignore_data", dout_v[0], 32'hDEADBEEF);
    @(negedge clk);
    wait_ack(0, g);
    g += 1;
    chk("busy_ignore_spacing", 32'(g), 32'd5);
    chk("busy_ignore_second", dout_v[0], 32'h00000034);
    req_v[0] = 1'b0;

    // Out of range.
    txn(0, 1'b0, 16'h0100, 32'h12345678, n, data, err);
    chk("oor_write_err", 32'(err), 32'd1);
    txn(0, 1'b1, 16'h0000, 32'h0, n, data, err);
    chk("oor_no_alias", data, 32'h11110000);
    chk("oor_no_alias_err", 32'(err), 32'd0);
    txn(0, 1'b1, 16'h0100, 32'h0, n, data, err);
    chk("oor_read_data", data, 32'd0);
    chk("oor_read_err", 32'(err), 32'd1);

    // Reset during WAIT discards the pending write.
    issue(0, 1'b0, 16'h0005, 32'hCAFEF00D);
    chk("busy_before_rst", 32'(busy_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_mid_ack",  32'(ack_v[0]),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b1, 16'h0005, 32'h0, n, data, err);
    chk("rst_mid_prior", data, 32'hA5A5A5A5);

    // Zero wait states.
    txn(1, 1'b0, 16'h0010, 32'h10000010, n, data, err);
    chk("ws0_write_latency", 32'(n), 32'd1);
    txn(1, 1'b0, 16'h0011, 32'h10000011, n, data, err);
    txn(1, 1'b1, 16'h0011, 32'h0, n, data, err);
    chk("ws0_read_latency", 32'(n), 32'd1);
    chk("ws0_read_data", data, 32'h10000011);

    @(negedge clk);
    req_v[1] = 1'b1; rw_v[1] = 1'b1; addr_v[1] = 16'h0010;
    @(negedge clk);
    wait_ack(1, n);
    chk("ws0_b2b_first", dout_v[1], 32'h10000010);
    addr_v[1] = 16'h0011;
    @(negedge clk);
    wait_ack(1, g);
    g += 1;
    chk("ws0_b2b_spacing", 32'(g), 32'd3);
    chk("ws0_b2b_second", dout_v[1], 32'h10000011);
    req_v[1] = 1'b0;

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Data-memory responder on the far end of the processor's RAM bus; the memory controller is the initiator.
- Accepts one LDR/STR request at a time: address, read/write flag, write data.
- Performs the access after a programmable number of wait states.
- Returns read data with a one-cycle acknowledge and flags out-of-range addresses.

Parameters:
- ADDR_WIDTH, 8: implemented word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2: extra cycles between request capture and access; 0 to 15 legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ram_req  input  1  request strobe from memory controller; sampled only in IDLE.
- ram_rw_flag  input  1  1 = read (LDR), 0 = write (STR).
- address_add_bus  input  16  word address from the address-bus mux.
- ram_data_in  input  32  write data (STR source register).
- ram_data_out  output  32  read data returned to controller.
- ram_ack  output  1  one-cycle completion pulse.
- ram_busy  output  1  high from capture until the ack cycle ends.
- ram_err  output  1  address out of range; valid with ram_ack.

Behaviour:
- Reset (asynchronous, any time): state = IDLE; ram_data_out = 0, ram_ack = 0, ram_busy = 0, ram_err = 0, wait counter = 0.
  - Any captured, uncommitted write is discarded.
  - Memory array contents are not cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On an edge with ram_req = 1: latch address, rw flag and write data; load counter = WAIT_STATES; set ram_busy = 1; go to WAIT.
  - With ram_req = 0: stay in IDLE.
- WAIT:
  - At each edge with counter != 0: decrement the counter.
  - At the edge with counter == 0: perform the access and go to ACK.
  - Write: mem[addr] <= latched data.
  - Read: ram_data_out <= mem[addr].
  - ram_ack <= 1 on the same edge.
- ACK:
  - ram_ack = 1 and ram_busy = 1 for exactly one cycle.
  - Next edge: ram_ack = 0, ram_busy = 0, return to IDLE.
  - No back-to-back capture from ACK: a ram_req held high is taken at the first IDLE edge.
- Latency: request sampled at edge N produces ram_ack high in the cycle after edge N+WAIT_STATES+1.
  - WAIT_STATES = 0 gives ack in the cycle after edge N+1.
  - Minimum request-to-request spacing is WAIT_STATES+3 cycles.
- Input stability:
  - ram_req, address and data are ignored while ram_busy = 1.
  - Only latched values are used; input changes after capture have no effect.
- ram_data_out behaviour:
  - Updated only by reads.
  - Holds its last value through writes, errors (see below) and idle cycles.
- Out-of-range: address_add_bus[15:ADDR_WIDTH] != 0 (no check when ADDR_WIDTH = 16).
  - Write: the memory is not modified.
  - Read: ram_data_out <= 0.
  - ram_err = 1 concurrently with ram_ack. ram_err is 0 at all other times.
- Array indexing: by address_add_bus[ADDR_WIDTH-1:0]; no wrap-around aliasing is permitted for out-of-range addresses.

Test Plan:
- Reset then idle: assert rst mid-cycle with no clock edge -> all outputs 0 immediately; ram_req = 0 for 10 cycles -> ram_ack never asserts.
- Write then read (WAIT_STATES = 2), same address:
  - Write 0xDEADBEEF to address 0x0012 (ram_rw_flag = 0) -> ram_ack in the cycle after edge N+3; ram_data_out unchanged.
  - Read 0x0012 -> ram_data_out = 0xDEADBEEF with ram_ack; ram_err = 0.
- Busy ignore: hold ram_req = 1 with an address change 0x0012 -> 0x0034 one cycle after capture -> access uses 0x0012.
  - A second request is captured only at the first edge after returning to IDLE.
- Out of range (ADDR_WIDTH = 8):
  - Write 0x12345678 to 0x0100 -> ram_err = 1 with ram_ack.
  - Read 0x0000 -> pre-existing value, not 0x12345678.
  - Read 0x0100 -> ram_data_out = 0, ram_err = 1.
- Reset mid-operation: write 0xCAFEF00D to 0x0005 and assert rst during WAIT -> state IDLE, ram_busy = 0; a read of 0x0005 returns the prior contents.
- WAIT_STATES = 0: read request at edge N -> ram_ack high in the cycle after edge N+1; back-to-back requests are serviced every 3 cycles.
